// File: rtl/i4001_pkg.sv
// Shared defaults and port identifiers for the i4001 instruction/data RAM arbiter.
package i4001_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/i4001_arbiter_if.sv
// Bundle of both requester ports and the RAM port shared by the i4001 arbiter.
interface i4001_arbiter_if #(
  parameter int ADDR_W = i4001_pkg::ADDR_W_DEF,
  parameter int DATA_W = i4001_pkg::DATA_W_DEF
) ();

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_dout,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           ram_we, ram_addr, ram_din
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_dout,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/i4001_arb_pick.sv
// Combinational winner selection between ports A and B.
// I4001_ARB_RR_EN selects round-robin on ties; otherwise port A has fixed priority.
module i4001_arb_pick
  import i4001_pkg::*;
(
  input  logic  a_elig,
  input  logic  b_elig,
`ifdef I4001_ARB_RR_EN
  input  port_t ptr,
`endif
  output logic  pick_a,
  output logic  pick_b
);

  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
`ifdef I4001_ARB_RR_EN
    if (a_elig && b_elig) begin
      pick_a = (ptr == PORT_A);
      pick_b = (ptr == PORT_B);
    end else begin
      pick_a = a_elig;
      pick_b = b_elig;
    end
`else
    pick_a = a_elig;
    pick_b = b_elig & ~a_elig;
`endif
  end

endmodule

// File: rtl/i4001_arbiter.sv
// Two-port arbiter in front of a synchronous-read RAM: port A fetch reads, port B loader reads/writes.
// I4001_ARB_RR_EN enables a round-robin tie pointer; default build is fixed priority to port A.
module i4001_arbiter
  import i4001_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  i4001_arbiter_if.slave bus
);

  logic              a_gnt_q, b_gnt_q;
  logic              a_rvalid_q, b_rvalid_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              a_elig, b_elig;
  logic              pick_a, pick_b;

  // a port holding gnt this cycle sits out, so held requests re-arbitrate two cycles later
  assign a_elig = bus.a_req & ~a_gnt_q;
  assign b_elig = bus.b_req & ~b_gnt_q;

`ifdef I4001_ARB_RR_EN
  port_t ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_A;
    end else if (pick_a) begin
      ptr_q <= PORT_B;
    end else if (pick_b) begin
      ptr_q <= PORT_A;
    end
  end

  i4001_arb_pick u_pick (
    .a_elig (a_elig),
    .b_elig (b_elig),
    .ptr    (ptr_q),
    .pick_a (pick_a),
    .pick_b (pick_b)
  );
`else
  i4001_arb_pick u_pick (
    .a_elig (a_elig),
    .b_elig (b_elig),
    .pick_a (pick_a),
    .pick_b (pick_b)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      a_gnt_q    <= pick_a;
      b_gnt_q    <= pick_b;
      a_rvalid_q <= a_gnt_q;
      // ram_we_q is high exactly in a port-B write grant cycle
      b_rvalid_q <= b_gnt_q & ~ram_we_q;
      ram_we_q   <= 1'b0;
      if (pick_a) begin
        ram_addr_q <= bus.a_addr;
      end else if (pick_b) begin
        ram_addr_q <= bus.b_addr;
        ram_we_q   <= bus.b_we;
        ram_din_q  <= bus.b_wdata;
      end
    end
  end

  assign bus.a_gnt    = a_gnt_q;
  assign bus.b_gnt    = b_gnt_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

endmodule

// File: tb/tb_i4001_arbiter.sv
// Directed bench for i4001_arbiter with a behavioural synchronous-read RAM.
module tb_i4001_arbiter;
  import i4001_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total_cnt = 0;
  int   bad_cnt = 0;

  logic [DW-1:0] mem [0:127];

  i4001_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  i4001_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = addr; bus.b_wdata = data;
    tick();
    check("bw_gnt", 32'(bus.b_gnt), 1);
    check("bw_we", 32'(bus.ram_we), 1);
    check("bw_addr", 32'(bus.ram_addr), 32'(addr));
    check("bw_din", 32'(bus.ram_din), 32'(data));
    bus.b_req = 1'b0; bus.b_we = 1'b0;
    tick();
    check("bw_no_rvalid", 32'(bus.b_rvalid), 0);
    check("bw_we_drop", 32'(bus.ram_we), 0);
  endtask

  task automatic b_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = addr;
    tick();
    check("br_gnt", 32'(bus.b_gnt), 1);
    check("br_we", 32'(bus.ram_we), 0);
    check("br_addr", 32'(bus.ram_addr), 32'(addr));
    bus.b_req = 1'b0;
    tick();
    check("br_rvalid", 32'(bus.b_rvalid), 1);
    check("br_rdata", 32'(bus.b_rdata), 32'(exp));
    check("br_a_rvalid", 32'(bus.a_rvalid), 0);
    tick();
    check("br_rvalid_1cyc", 32'(bus.b_rvalid), 0);
  endtask

  task automatic a_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.a_req = 1'b1; bus.a_addr = addr;
    tick();
    check("ar_gnt", 32'(bus.a_gnt), 1);
    check("ar_addr", 32'(bus.ram_addr), 32'(addr));
    check("ar_we", 32'(bus.ram_we), 0);
    bus.a_req = 1'b0;
    tick();
    check("ar_rvalid", 32'(bus.a_rvalid), 1);
    check("ar_rdata", 32'(bus.a_rdata), 32'(exp));
    tick();
    check("ar_rvalid_1cyc", 32'(bus.a_rvalid), 0);
  endtask

  initial begin
    logic exp_a;
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // asynchronous reset, sampled before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_gnt", 32'(bus.a_gnt), 0);
    check("rst_b_gnt", 32'(bus.b_gnt), 0);
    check("rst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_din", 32'(bus.ram_din), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'({bus.a_gnt, bus.b_gnt}), 0);

    // preload and single reads
    b_write(7'h10, 16'hBEEF);
    b_write(7'h05, 16'h5555);
    a_read(7'h10, 16'hBEEF);

    // write then read back the top word
    b_write(7'h7F, 16'h1234);
    b_read(7'h7F, 16'h1234);

    // idle: RAM port holds last address/data, no write
    repeat (2) tick();
    check("hold_addr", 32'(bus.ram_addr), 32'h7F);
    check("hold_din", 32'(bus.ram_din), 32'h1234);
    check("hold_we", 32'(bus.ram_we), 0);

    // single simultaneous request: A first, B next cycle
    bus.a_req = 1'b1; bus.a_addr = 7'h10;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'h05;
    tick();
    check("tie1_a_gnt", 32'(bus.a_gnt), 1);
    check("tie1_b_gnt", 32'(bus.b_gnt), 0);
    bus.a_req = 1'b0;
    tick();
    check("tie2_b_gnt", 32'(bus.b_gnt), 1);
    check("tie2_a_gnt", 32'(bus.a_gnt), 0);
    check("tie2_addr", 32'(bus.ram_addr), 32'h05);
    check("tie2_a_rdata", 32'(bus.a_rdata), 32'hBEEF);
    bus.b_req = 1'b0;
    tick();
    check("tie3_b_rvalid", 32'(bus.b_rvalid), 1);
    check("tie3_b_rdata", 32'(bus.b_rdata), 32'h5555);
    repeat (2) tick();

    // both held for six cycles: strict alternation starting with A
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("alt_a_gnt", 32'(bus.a_gnt), 32'((i % 2) == 0));
      check("alt_b_gnt", 32'(bus.b_gnt), 32'((i % 2) == 1));
      check("alt_addr", 32'(bus.ram_addr), ((i % 2) == 0) ? 32'h10 : 32'h05);
      if (i > 0) begin
        check("alt_a_rvalid", 32'(bus.a_rvalid), 32'((i % 2) == 1));
        check("alt_rdata", 32'(bus.a_rdata), ((i % 2) == 1) ? 32'hBEEF : 32'h5555);
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (3) tick();

    // last grant to A, then a fresh tie: round-robin favours B, fixed priority favours A
    a_read(7'h10, 16'hBEEF);
`ifdef I4001_ARB_RR_EN
    exp_a = 1'b0;
`else
    exp_a = 1'b1;
`endif
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    tick();
    check("tie_ptr_a", 32'(bus.a_gnt), 32'(exp_a));
    check("tie_ptr_b", 32'(bus.b_gnt), 32'(!exp_a));
    if (exp_a) bus.a_req = 1'b0; else bus.b_req = 1'b0;
    tick();
    check("tie_ptr_other", 32'({bus.a_gnt, bus.b_gnt}), exp_a ? 32'b01 : 32'b10);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (3) tick();

    // hold-over: a_req kept high through its grant
    bus.a_req = 1'b1; bus.a_addr = 7'h10;
    tick();
    check("ho_gnt1", 32'(bus.a_gnt), 1);
    tick();
    check("ho_gap", 32'(bus.a_gnt), 0);
    tick();
    check("ho_regrant", 32'(bus.a_gnt), 1);
    check("ho_b_gnt", 32'(bus.b_gnt), 0);
    bus.a_req = 1'b0;
    repeat (3) tick();

    // reset in the middle of a read of 0x05
    bus.a_req = 1'b1; bus.a_addr = 7'h05;
    tick();
    check("mr_gnt", 32'(bus.a_gnt), 1);
    bus.a_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr_a_gnt", 32'(bus.a_gnt), 0);
    check("mr_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 0);
    check("mr_we", 32'(bus.ram_we), 0);
    check("mr_addr", 32'(bus.ram_addr), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_post_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 0);
      check("mr_post_gnt", 32'({bus.a_gnt, bus.b_gnt}), 0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/i4001_arbiter.md
I4001_ARBITER -- requirements
Module: i4001_arbiter

Interface
REQ-001 Parameter ADDR_W, 7, RAM address width (128 words).
REQ-002 Parameter DATA_W, 16, RAM data width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 a_req  in  1  port A (fetch, read-only) request.
REQ-006 a_addr  in  ADDR_W  port A read address.
REQ-007 a_gnt  out  1  port A grant pulse.
REQ-008 a_rvalid  out  1  port A read data valid.
REQ-009 a_rdata  out  DATA_W  port A read data.
REQ-010 b_req  in  1  port B (loader/debug) request.
REQ-011 b_we  in  1  port B write enable; 1 = write, 0 = read.
REQ-012 b_addr  in  ADDR_W  port B address.
REQ-013 b_wdata  in  DATA_W  port B write data.
REQ-014 b_gnt  out  1  port B grant pulse.
REQ-015 b_rvalid  out  1  port B read data valid; never set for writes.
REQ-016 b_rdata  out  DATA_W  port B read data.
REQ-017 ram_we  out  1  to RAM WE.
REQ-018 ram_addr  out  ADDR_W  to RAM address.
REQ-019 ram_din  out  DATA_W  to RAM data in.
REQ-020 ram_dout  in  DATA_W  from RAM data out; valid one cycle after address presented (synchronous read).

Function
REQ-021 Arbitration in cycle T over eligible ports (req high, gnt not high in T); winner's gnt, and ram_addr/ram_we/ram_din, SHALL be registered and visible in T+1.
REQ-022 At most one gnt SHALL be high per cycle; ram_we SHALL be high only in a grant cycle of a port-B write.
REQ-023 A port with gnt high in the current cycle SHALL be ineligible that cycle; req still high in T+2 is a new request.
REQ-024 Requester SHALL hold req, addr, we, wdata stable until gnt; arbiter samples them in decision cycle T only.
REQ-025 Read granted in T+1 SHALL assert that port's rvalid in T+2 for exactly one cycle, rdata = ram_dout (word at granted address).
REQ-026 a_rdata and b_rdata SHALL both be driven from ram_dout; only rvalid distinguishes owner.
REQ-027 With no eligible request, ram_we SHALL be 0 and ram_addr/ram_din SHALL hold last value.
REQ-028 Write then read of same address by consecutive grants SHALL return the new data (RAM write-first not assumed; read issued a cycle after write).
REQ-029 Both ports continuously requesting SHALL alternate grants, one RAM access per cycle.

Reset
REQ-030 RST_N low SHALL immediately clear a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we to 0, ram_addr and ram_din to 0, priority pointer to port A.
REQ-031 Reset mid-transaction SHALL discard granted and in-flight reads; no rvalid after release without a new grant.
REQ-032 First arbitration SHALL occur in the first rising edge with RST_N high.

Configuration
REQ-033 Macro I4001_ARB_RR_EN defined: round-robin; on simultaneous eligible requests the port not granted last wins; pointer updates only on a grant.
REQ-034 Macro I4001_ARB_RR_EN undefined: fixed priority, port A always wins ties; pointer logic absent.

Structure
REQ-035 Package i4001_pkg SHALL hold ADDR_W/DATA_W defaults and port-id enum (PORT_A, PORT_B).
REQ-036 Sub-module i4001_arb_pick SHALL hold the combinational winner selection (eligibility, pointer in, winner out).

Verification
REQ-037 Reset: RST_N low mid-read of addr 0x05 -> all gnt/rvalid/ram_we 0 asynchronously, no rvalid after release.
REQ-038 Single read: a_req, a_addr=0x10, RAM[0x10]=0xBEEF -> a_gnt at T+1, ram_addr=0x10, a_rvalid and a_rdata=0xBEEF at T+2.
REQ-039 Write/readback: B write 0x7F<-0x1234, then B read 0x7F -> ram_we one cycle, b_rvalid with 0x1234, no b_rvalid for write.
REQ-040 Contention with I4001_ARB_RR_EN: both req held for 6 cycles -> grants A,B,A,B..., one per cycle.
REQ-041 Contention without macro: both request once -> A granted first, B on next cycle.
REQ-042 Hold-over: a_req kept high through a_gnt -> no gnt in grant cycle, regrant no earlier than T+3.
